// File: rtl/instr_fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch/sequence stage.
// Holds the FSM state encoding, the ROM class-select codes and the default halt opcode.
// Optional single-step build: INSTR_FETCH_SINGLE_STEP_EN (used by the top level only).
package instr_fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] EN_IDLE = 2'b00;
  localparam logic [1:0] EN_REG  = 2'b01;
  localparam logic [1:0] EN_IMM  = 2'b10;

  localparam logic [7:0] HALT_OPC_DEFAULT = 8'h7F;

  // Bit 7 of the instruction picks the ROM: immediate class when set, register/ALU otherwise.
  function automatic logic [1:0] en_class(input logic [7:0] ir);
    return ir[7] ? EN_IMM : EN_REG;
  endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Program-memory read port plus the instruction/class-select bus to the microcode ROMs.
// Memory data returns one cycle after mem_rd; ROM outputs are combinational from the sequencer.
// No backpressure: the ROMs and memory are assumed to accept every cycle.
interface instr_fetch_seq_if #(
  parameter int ADDR_W = 4
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic [7:0]        instr;
  logic [1:0]        en;
  logic              instr_done;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data,
    output instr,
    output en,
    output instr_done
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data,
    input  instr,
    input  en,
    input  instr_done
  );

endinterface

// File: rtl/instr_fetch_seq_pc_counter.sv
// Program counter register with increment enable; wraps naturally at 2^ADDR_W.
// Latency: the incremented value appears the cycle after inc is sampled high.
// No backpressure; synchronous active-low reset clears it to zero.
module pc_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // Advance by one on request; the top address rolls over to zero by width truncation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/sequence stage: reads instructions at pc, latches IR, drives en for EXEC_CYCLES, then advances pc.
// Latency: 2+EXEC_CYCLES cycles per instruction; first en 3 cycles after run rises in IDLE.
// No backpressure; run gates new fetches only. Optional step gating via INSTR_FETCH_SINGLE_STEP_EN.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int         ADDR_W      = 4,
  parameter int         EXEC_CYCLES = 2,
  parameter logic [7:0] HALT_OPC    = HALT_OPC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
`ifdef INSTR_FETCH_SINGLE_STEP_EN
  input  logic                  step,
  input  logic                  step_mode,
`endif
  instr_fetch_seq_if.master     bus,
  output logic [ADDR_W-1:0]     pc,
  output logic                  halted
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       ir;
  logic [CNT_W-1:0] cnt;
  logic             pc_inc;
  logic             mem_rd;
  logic [1:0]       en;
  logic             instr_done;
  logic             go;
  logic             single;

`ifdef INSTR_FETCH_SINGLE_STEP_EN
  // In step mode an IDLE visit is left only on a step cycle, and every instruction returns to IDLE.
  assign go     = run && (!step_mode || step);
  assign single = step_mode;
`else
  assign go     = run;
  assign single = 1'b0;
`endif

  pc_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // State register, instruction register and execute-window counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_LOAD) begin
        ir  <= bus.mem_data;
        cnt <= '0;
      end else if (state == ST_EXEC) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Next-state decode and per-state strobes; pc only moves on the final execute cycle.
  always_comb begin
    state_nxt  = state;
    mem_rd     = 1'b0;
    en         = EN_IDLE;
    instr_done = 1'b0;
    pc_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd    = 1'b1;
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = (bus.mem_data == HALT_OPC) ? ST_HALTED : ST_EXEC;
      end
      ST_EXEC: begin
        en = en_class(ir);
        if (cnt == CNT_LAST) begin
          instr_done = 1'b1;
          pc_inc     = 1'b1;
          state_nxt  = (run && !single) ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_addr   = pc;
  assign bus.mem_rd     = mem_rd;
  assign bus.instr      = ir;
  assign bus.en         = en;
  assign bus.instr_done = instr_done;
  assign halted         = (state == ST_HALTED);

endmodule
